// File: rtl/fp_divider.sv
// Sequential IEEE-754 single-precision divider (restoring, one quotient bit per clock).
// Optional round-to-nearest-even stage enabled by defining FP_DIV_ROUND_EN.
module fp_divider #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23,
    parameter int BIAS   = 127
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [EXP_W+MANT_W:0]   a_in,
    input  logic [EXP_W+MANT_W:0]   b_in,
    output logic [EXP_W+MANT_W:0]   result,
    output logic                    of,
    output logic                    uf,
    output logic                    dz,
    output logic                    busy,
    output logic                    done
);
    localparam int W     = EXP_W + MANT_W + 1;
    localparam int SIG_W = MANT_W + 1;
    localparam int Q_W   = MANT_W + 3;
    localparam int E_W   = EXP_W + 2;
    localparam int CNT_W = $clog2(Q_W + 1);
    localparam logic signed [E_W-1:0] E_MAX  = E_W'((1 << EXP_W) - 1);
    localparam logic signed [E_W-1:0] E_ZERO = '0;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_DIVIDE, S_NORM, S_ROUND, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [W-1:0]            a_q, a_d, b_q, b_d;
    logic [SIG_W:0]          rem_q, rem_d;
    logic [Q_W-1:0]          quo_q, quo_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [E_W-1:0]   exp_q, exp_d;
    logic [W-1:0]            pend_res_q, pend_res_d, result_q, result_d;
    logic                    pend_of_q, pend_of_d, pend_uf_q, pend_uf_d, pend_dz_q, pend_dz_d;
    logic                    of_q, of_d, uf_q, uf_d, dz_q, dz_d, done_q, done_d;
`ifdef FP_DIV_ROUND_EN
    logic [MANT_W-1:0]       mant_q, mant_d;
    logic                    grd_q, grd_d, stk_q, stk_d;
    logic                    inc, carry;
    logic [MANT_W-1:0]       rnd_mant;
`endif

    logic                    sq, a_inf, b_inf, a_zero, b_zero;
    logic [EXP_W-1:0]        ea, eb;
    logic [SIG_W-1:0]        ma, mb;
    logic [SIG_W:0]          rem_sub;
    logic [MANT_W-1:0]       norm_mant;
    logic signed [E_W-1:0]   norm_exp;

    // Returns {of, uf, result} after range checking the biased exponent.
    function automatic logic [W+1:0] pack(input logic s, input logic signed [E_W-1:0] e,
                                          input logic [MANT_W-1:0] m);
        if (e >= E_MAX)  return {2'b10, s, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
        if (e <= E_ZERO) return {2'b01, s, {(W-1){1'b0}}};
        return {2'b00, s, e[EXP_W-1:0], m};
    endfunction

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        exp_d      = exp_q;
        pend_res_d = pend_res_q;
        pend_of_d  = pend_of_q;
        pend_uf_d  = pend_uf_q;
        pend_dz_d  = pend_dz_q;
        result_d   = result_q;
        of_d       = of_q;
        uf_d       = uf_q;
        dz_d       = dz_q;
        done_d     = 1'b0;
`ifdef FP_DIV_ROUND_EN
        mant_d     = mant_q;
        grd_d      = grd_q;
        stk_d      = stk_q;
        inc        = grd_q & (stk_q | mant_q[0]);
        {carry, rnd_mant} = {1'b0, mant_q} + {{MANT_W{1'b0}}, inc};
`endif
        sq      = a_q[W-1] ^ b_q[W-1];
        ea      = a_q[W-2:MANT_W];
        eb      = b_q[W-2:MANT_W];
        ma      = {1'b1, a_q[MANT_W-1:0]};
        mb      = {1'b1, b_q[MANT_W-1:0]};
        a_inf   = &ea;
        b_inf   = &eb;
        a_zero  = ~|ea;
        b_zero  = ~|eb;
        rem_sub = rem_q - {1'b0, mb};
        if (quo_q[Q_W-1]) begin
            norm_mant = quo_q[Q_W-2:2];
            norm_exp  = exp_q;
        end else begin
            norm_mant = quo_q[Q_W-3:1];
            norm_exp  = exp_q - E_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                pend_of_d = 1'b0;
                pend_uf_d = 1'b0;
                pend_dz_d = 1'b0;
                state_d   = S_DONE;
                if (a_inf || b_inf) begin
                    pend_res_d = QNAN;
                end else if (a_zero) begin
                    pend_res_d = {sq, {(W-1){1'b0}}};
                end else if (b_zero) begin
                    pend_dz_d  = 1'b1;
                    pend_res_d = {sq, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
                end else begin
                    rem_d   = {1'b0, ma};
                    quo_d   = '0;
                    cnt_d   = '0;
                    exp_d   = {2'b00, ea} - {2'b00, eb} + E_W'(BIAS);
                    state_d = S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                // Remainder stays below 2*mb, so the shifted value always fits SIG_W+1 bits.
                if (rem_q >= {1'b0, mb}) begin
                    rem_d = {rem_sub[SIG_W-1:0], 1'b0};
                    quo_d = {quo_q[Q_W-2:0], 1'b1};
                end else begin
                    rem_d = {rem_q[SIG_W-1:0], 1'b0};
                    quo_d = {quo_q[Q_W-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(Q_W - 1)) state_d = S_NORM;
            end
            S_NORM: begin
`ifdef FP_DIV_ROUND_EN
                mant_d  = norm_mant;
                exp_d   = norm_exp;
                grd_d   = quo_q[Q_W-1] ? quo_q[1] : quo_q[0];
                stk_d   = (quo_q[Q_W-1] & quo_q[0]) | (|rem_q);
                state_d = S_ROUND;
`else
                {pend_of_d, pend_uf_d, pend_res_d} = pack(sq, norm_exp, norm_mant);
                state_d = S_DONE;
`endif
            end
`ifdef FP_DIV_ROUND_EN
            S_ROUND: begin
                {pend_of_d, pend_uf_d, pend_res_d} =
                    pack(sq, exp_q + {{(E_W-1){1'b0}}, carry}, rnd_mant);
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                result_d = pend_res_q;
                of_d     = pend_of_q;
                uf_d     = pend_uf_q;
                dz_d     = pend_dz_q;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            exp_q      <= '0;
            pend_res_q <= '0;
            pend_of_q  <= 1'b0;
            pend_uf_q  <= 1'b0;
            pend_dz_q  <= 1'b0;
            result_q   <= '0;
            of_q       <= 1'b0;
            uf_q       <= 1'b0;
            dz_q       <= 1'b0;
            done_q     <= 1'b0;
`ifdef FP_DIV_ROUND_EN
            mant_q     <= '0;
            grd_q      <= 1'b0;
            stk_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            exp_q      <= exp_d;
            pend_res_q <= pend_res_d;
            pend_of_q  <= pend_of_d;
            pend_uf_q  <= pend_uf_d;
            pend_dz_q  <= pend_dz_d;
            result_q   <= result_d;
            of_q       <= of_d;
            uf_q       <= uf_d;
            dz_q       <= dz_d;
            done_q     <= done_d;
`ifdef FP_DIV_ROUND_EN
            mant_q     <= mant_d;
            grd_q      <= grd_d;
            stk_q      <= stk_d;
`endif
        end
    end

    assign result = result_q;
    assign of     = of_q;
    assign uf     = uf_q;
    assign dz     = dz_q;
    assign done   = done_q;
    assign busy   = (state_q != S_IDLE);
endmodule
